ins_fetch_queue: RTL and testbench
==================================

INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, giving the number of prefetch queue entries; only 4 is required to be supported.
REQ-002 The block SHALL use one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-003 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 REQ_ADDR  input  8  address of the instruction the CPU core requests.
REQ-006 REQ_VALID  input  1  request strobe; one instruction SHALL be consumed per cycle in which REQ_VALID and INS_VALID are both 1.
REQ-007 INS  output  21  instruction word for REQ_ADDR; SHALL be 21'b0 whenever INS_VALID=0.
REQ-008 INS_VALID  output  1  INS holds the instruction at REQ_ADDR; combinational from queue head, bypass path and REQ_ADDR.
REQ-009 ROM_ADDR  output  8  read address to the synchronous instruction ROM.
REQ-010 ROM_EN  output  1  ROM read strobe; ROM_DATA is valid exactly one cycle after ROM_EN=1.
REQ-011 ROM_DATA  input  21  ROM read data.
REQ-012 MISS_CNT  output  8  saturating count of redirects.

Function
REQ-013 The FSM SHALL have two states: IDLE (no prefetch, ROM_EN=0) and STREAM.
REQ-014 IDLE SHALL go to STREAM on the first cycle with REQ_VALID=1; that cycle SHALL be treated as a miss. STREAM SHALL never return to IDLE except via reset.
REQ-015 Each queue entry SHALL hold an 8-bit address tag and a 21-bit instruction. A one-bit in-flight flag plus an 8-bit in-flight tag SHALL track the outstanding ROM read.
REQ-016 A hit SHALL occur when REQ_VALID=1 and one of these holds: the queue is non-empty and its head tag equals REQ_ADDR, or the queue is empty, a read is in flight and its tag equals REQ_ADDR (bypass: INS=ROM_DATA).
REQ-017 On a hit, INS_VALID SHALL be 1 and the head entry (or the bypassed data) SHALL be consumed; bypassed data SHALL NOT be written to the queue.
REQ-018 A miss SHALL occur when REQ_VALID=1 and no hit occurs. On a miss:
- the queue SHALL be flushed;
- any data returning that cycle SHALL be discarded;
- ROM_ADDR=REQ_ADDR and ROM_EN=1 in the same cycle;
- the fetch PC SHALL become REQ_ADDR+1 (mod 256);
- MISS_CNT SHALL increment, saturating at 255.
REQ-019 Miss latency: a request that misses in cycle N SHALL be a bypass hit in cycle N+1 if REQ_ADDR is held.
REQ-020 In STREAM with no miss, ROM_EN SHALL be 1, with ROM_ADDR = fetch PC and fetch PC incremented, iff (queue count + in-flight − consumed this cycle) < DEPTH.
REQ-021 Returning ROM_DATA that is not bypassed and not discarded SHALL be pushed at the queue tail with its in-flight tag; overflow SHALL be impossible by REQ-020.
REQ-022 Fetch PC and tags SHALL wrap 255→0 with no miss generated by the wrap.
REQ-023 When REQ_VALID=0, INS_VALID SHALL be 0 and no state other than prefetch and fill SHALL change.
REQ-024 Simultaneous pop, push and issue in one cycle SHALL be supported, giving a sustained throughput of one instruction per cycle.

Reset
REQ-025 While reset_n=0, asynchronously:
- state=IDLE; queue empty; in-flight flag=0;
- fetch PC=0; MISS_CNT=0;
- INS=0, INS_VALID=0, ROM_EN=0, ROM_ADDR=0.
REQ-026 ROM_DATA arriving in the cycle after reset deassertion SHALL be ignored.
REQ-027 The first request after any reset SHALL be a miss.

Verification (ROM[a] = {13'b0, a})
REQ-028 Reset, then REQ_ADDR=0,1,2,…,9 with REQ_VALID=1 → INS_VALID=0 in cycle 0; INS=0..9 in cycles 1–10 back-to-back; MISS_CNT=1.
REQ-029 While streaming at address 5, request 40 → INS_VALID=0 for one cycle, then INS=40, 41, …; entries 6–8 are never output; MISS_CNT=2.
REQ-030 Hold REQ_VALID=0 for 6 cycles mid-stream → ROM_EN drops once 4 entries are queued; on resume, 4 consecutive hits occur with no gap, then streaming continues.
REQ-031 Request 254, then 255, 0, 1 → one miss at 254 only; INS=255, 0, 1 returned as hits.
REQ-032 Pull reset_n low between clock edges mid-stream → INS_VALID, ROM_EN and MISS_CNT go to 0 immediately; the next request misses.
REQ-033 Issue 300 alternating non-sequential requests → MISS_CNT reads 255 and holds.

Source files
------------

// File: rtl/ins_fetch_queue.sv
// ins_fetch_queue
//   Instruction prefetch queue between a CPU core and a synchronous
//   instruction ROM. Once the core starts requesting, the block streams
//   sequential addresses from the ROM into a small FIFO. Requests are served
//   either from the FIFO head or, when the FIFO is empty, straight from the
//   ROM read that is still in flight (bypass). Any other request is a miss.
//   A miss flushes the queue, redirects the fetch PC and bumps MISS_CNT.
//
// Ports
//   CLK        in   1   clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   REQ_ADDR   in   8   address requested by the core
//   REQ_VALID  in   1   request strobe
//   INS        out  21  instruction for REQ_ADDR (zero when INS_VALID=0)
//   INS_VALID  out  1   INS is valid this cycle (hit)
//   ROM_ADDR   out  8   ROM read address
//   ROM_EN     out  1   ROM read strobe (data returns next cycle)
//   ROM_DATA   in   21  ROM read data
//   MISS_CNT   out  8   saturating miss counter
module ins_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic [7:0]  REQ_ADDR,
    input  logic        REQ_VALID,
    output logic [20:0] INS,
    output logic        INS_VALID,
    output logic [7:0]  ROM_ADDR,
    output logic        ROM_EN,
    input  logic [20:0] ROM_DATA,
    output logic [7:0]  MISS_CNT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [7:0]      r_tag  [DEPTH];
    logic [20:0]     r_data [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_inflight;
    logic [7:0]      r_inflight_tag;
    logic [7:0]      r_pc;
    logic [7:0]      r_miss_cnt;

    logic            w_empty;
    logic            w_head_hit;
    logic            w_byp_hit;
    logic            w_hit;
    logic            w_miss;
    logic            w_push;
    logic            w_issue;
    logic [CW:0]     w_occ;

    // Pointer advance with wrap at DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Hit/miss classification and prefetch decision.
    always_comb begin
        w_empty    = (r_count == {CW{1'b0}});
        w_head_hit = REQ_VALID && !w_empty && (r_tag[r_rd_ptr] == REQ_ADDR);
        w_byp_hit  = REQ_VALID && w_empty && r_inflight && (r_inflight_tag == REQ_ADDR);
        w_hit      = w_head_hit || w_byp_hit;
        w_miss     = REQ_VALID && !w_hit;
        // Returning data goes into the queue unless the core took it directly
        // or a redirect makes it stale.
        w_push     = r_inflight && !w_byp_hit && !w_miss;
        // Entries that will be held after this cycle, counting the read in
        // flight; a new read may only be launched if it will have room.
        w_occ      = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_hit);
        w_issue    = (r_state == S_STREAM) && !w_miss && (w_occ < (CW+1)'(DEPTH));
    end

    // FSM next state: the first request leaves IDLE for good.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    w_state_nx = S_STREAM;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_STREAM: w_state_nx = S_STREAM;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Output decode; reset_n gates the combinational outputs so they drop
    // immediately when reset is asserted between clock edges.
    always_comb begin
        INS       = 21'd0;
        INS_VALID = 1'b0;
        ROM_EN    = 1'b0;
        ROM_ADDR  = 8'd0;
        MISS_CNT  = r_miss_cnt;
        if (reset_n) begin
            INS_VALID = w_hit;
            if (w_head_hit) begin
                INS = r_data[r_rd_ptr];
            end else if (w_byp_hit) begin
                INS = ROM_DATA;
            end else begin
                INS = 21'd0;
            end
            ROM_EN = w_miss || w_issue;
            if (w_miss) begin
                ROM_ADDR = REQ_ADDR;
            end else if (w_issue) begin
                ROM_ADDR = r_pc;
            end else begin
                ROM_ADDR = 8'd0;
            end
        end else begin
            MISS_CNT = 8'd0;
        end
    end

    // Control state: FSM, pointers, in-flight tracking, fetch PC, miss count.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_rd_ptr       <= {PW{1'b0}};
            r_wr_ptr       <= {PW{1'b0}};
            r_count        <= {CW{1'b0}};
            r_inflight     <= 1'b0;
            r_inflight_tag <= 8'd0;
            r_pc           <= 8'd0;
            r_miss_cnt     <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            if (w_miss) begin
                r_rd_ptr       <= {PW{1'b0}};
                r_wr_ptr       <= {PW{1'b0}};
                r_count        <= {CW{1'b0}};
                r_inflight     <= 1'b1;
                r_inflight_tag <= REQ_ADDR;
                r_pc           <= REQ_ADDR + 8'd1;
                if (r_miss_cnt != 8'd255) begin
                    r_miss_cnt <= r_miss_cnt + 8'd1;
                end
            end else begin
                if (w_head_hit) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                r_count    <= r_count + CW'(w_push) - CW'(w_head_hit);
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_tag <= r_pc;
                    r_pc           <= r_pc + 8'd1;
                end
            end
        end
    end

    // Queue storage: fill tail with returning ROM data and its tag.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]  <= 8'd0;
                r_data[i] <= 21'd0;
            end
        end else if (w_push) begin
            r_tag[r_wr_ptr]  <= r_inflight_tag;
            r_data[r_wr_ptr] <= ROM_DATA;
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Testbench for ins_fetch_queue. Models the ROM as ROM[a] = {13'b0, a} and
// keeps a reference model of the fetch unit as a single ordered list of
// addresses already requested from the ROM (queued or still in flight).
module tb_ins_fetch_queue;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  REQ_ADDR = 8'd0;
    logic        REQ_VALID = 1'b0;
    logic [20:0] INS;
    logic        INS_VALID;
    logic [7:0]  ROM_ADDR;
    logic        ROM_EN;
    logic [20:0] ROM_DATA = 21'd0;
    logic [7:0]  MISS_CNT;

    always #5 CLK = ~CLK;

    ins_fetch_queue #(.DEPTH(4)) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_VALID (REQ_VALID),
        .INS       (INS),
        .INS_VALID (INS_VALID),
        .ROM_ADDR  (ROM_ADDR),
        .ROM_EN    (ROM_EN),
        .ROM_DATA  (ROM_DATA),
        .MISS_CNT  (MISS_CNT)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    int   pend[$];      // addresses fetched and not yet consumed, oldest first
    int   m_pc;
    bit   m_stream;
    int   m_miss;
    int   obs_hits;
    logic [7:0] cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_pc     = 0;
        m_stream = 1'b0;
        m_miss   = 0;
    endtask

    // One clock cycle: drive request, check outputs against the model,
    // advance the model, then present ROM data for the next cycle.
    task automatic step(input bit v, input logic [7:0] a, output bit hit);
        bit         miss;
        bit         e_en;
        logic [7:0] e_addr;
        int         occ;
        logic       rom_en_s;
        logic [7:0] rom_addr_s;
        @(negedge CLK);
        REQ_VALID = v;
        REQ_ADDR  = a;
        #1;
        hit    = v && (pend.size() > 0) && (pend[0] == int'(a));
        miss   = v && !hit;
        occ    = pend.size() - (hit ? 1 : 0);
        e_en   = miss || (m_stream && occ < 4);
        e_addr = miss ? a : 8'(m_pc);
        chk("ins_valid", {31'd0, INS_VALID}, {31'd0, hit});
        chk("ins", {11'd0, INS}, hit ? {24'd0, a} : 32'd0);
        chk("rom_en", {31'd0, ROM_EN}, {31'd0, e_en});
        if (e_en) chk("rom_addr", {24'd0, ROM_ADDR}, {24'd0, e_addr});
        chk("miss_cnt", {24'd0, MISS_CNT}, m_miss);
        if (INS_VALID === 1'b1) obs_hits++;
        rom_en_s   = ROM_EN;
        rom_addr_s = ROM_ADDR;
        @(posedge CLK);
        if (miss) begin
            pend.delete();
            pend.push_back(int'(a));
            m_pc     = (int'(a) + 1) % 256;
            m_stream = 1'b1;
            if (m_miss < 255) m_miss++;
        end else begin
            if (hit) void'(pend.pop_front());
            if (e_en) begin
                pend.push_back(m_pc);
                m_pc = (m_pc + 1) % 256;
            end
        end
        #1;
        ROM_DATA = (rom_en_s === 1'b1) ? {13'd0, rom_addr_s} : 21'($urandom);
    endtask

    // A core that walks sequentially, holding the address until it hits,
    // with optional idle cycles and random redirects (percentages).
    task automatic core(input int n, input int p_idle, input int p_jump);
        bit v;
        bit h;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(99) >= p_idle);
            if (v && ($urandom_range(99) < p_jump)) cur = 8'($urandom);
            step(v, cur, h);
            if (h) cur = cur + 8'd1;
        end
    endtask

    // Assert reset between clock edges and check outputs drop at once.
    task automatic async_reset(input bit v);
        @(negedge CLK);
        REQ_VALID = v;
        REQ_ADDR  = 8'h33;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_ins_valid", {31'd0, INS_VALID}, 32'd0);
        chk("rst_ins", {11'd0, INS}, 32'd0);
        chk("rst_rom_en", {31'd0, ROM_EN}, 32'd0);
        chk("rst_rom_addr", {24'd0, ROM_ADDR}, 32'd0);
        chk("rst_miss_cnt", {24'd0, MISS_CNT}, 32'd0);
        @(posedge CLK);
        #1;
        ROM_DATA = 21'($urandom);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        reset_n   = 1'b1;
        model_reset();
    endtask

    initial begin
        bit h;
        model_reset();

        // Reset, then a sequential run 0..9
        async_reset(1'b0);
        cur = 8'd0;
        obs_hits = 0;
        core(11, 0, 0);
        chk("seq_hits", obs_hits, 32'd10);
        chk("seq_miss_cnt", {24'd0, MISS_CNT}, 32'd1);

        // Redirect from 5 to 40 while streaming
        async_reset(1'b1);
        cur = 8'd0;
        core(7, 0, 0);
        cur = 8'd40;
        obs_hits = 0;
        core(5, 0, 0);
        chk("redirect_hits", obs_hits, 32'd4);
        chk("redirect_miss_cnt", {24'd0, MISS_CNT}, 32'd2);

        // Stall 6 cycles, queue fills, then 4 back-to-back hits
        core(4, 0, 0);
        for (int i = 0; i < 6; i++) step(1'b0, cur, h);
        chk("stall_rom_en", {31'd0, ROM_EN}, 32'd0);
        obs_hits = 0;
        core(4, 0, 0);
        chk("resume_hits", obs_hits, 32'd4);
        chk("resume_miss_cnt", {24'd0, MISS_CNT}, 32'd2);

        // Address wrap 254 -> 255 -> 0 -> 1
        cur = 8'd254;
        obs_hits = 0;
        core(5, 0, 0);
        chk("wrap_hits", obs_hits, 32'd4);
        chk("wrap_miss_cnt", {24'd0, MISS_CNT}, 32'd3);

        // Randomised traffic with idles and redirects
        core(400, 20, 10);

        // Mid-stream asynchronous reset, next request must miss
        async_reset(1'b1);
        step(1'b1, 8'h21, h);
        chk("post_reset_miss_cnt", {24'd0, MISS_CNT}, 32'd1);
        cur = 8'h21;
        core(6, 0, 0);

        // Miss counter saturation
        for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 1) ? 8'h10 : 8'h80, h);
        chk("sat_miss_cnt", {24'd0, MISS_CNT}, 32'd255);
        for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 1) ? 8'h10 : 8'h80, h);
        chk("sat_hold_miss_cnt", {24'd0, MISS_CNT}, 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
